// File: rtl/generic_sc_adapter_fifo_core.sv
// Single-clock show-ahead FIFO that accepts wide words and returns them as
// DATA_RATIO narrow slices, least-significant slice first.
module generic_sc_adapter_fifo_core #(
  parameter int WR_ADDR_W = 5,
  parameter int WR_DATA_W = 32,
  parameter int RD_DATA_W = 16,
  localparam int DATA_RATIO = WR_DATA_W / RD_DATA_W,
  localparam int EXTEND_W   = $clog2(DATA_RATIO),
  localparam int RD_ADDR_W  = WR_ADDR_W + EXTEND_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [WR_DATA_W-1:0] wr_data_i,
  output logic [WR_ADDR_W:0]   wr_usedw_o,
  output logic                 wr_empty_o,
  output logic                 wr_full_o,
  input  logic                 rd_en_i,
  output logic [RD_DATA_W-1:0] rd_data_o,
  output logic [RD_ADDR_W:0]   rd_usedw_o,
  output logic                 rd_empty_o,
  output logic                 rd_full_o
);

  localparam int DEPTH = 2 ** WR_ADDR_W;
  // keeps rd_sub at least one bit wide when the ratio is 1
  localparam int SUB_W = (EXTEND_W > 0) ? EXTEND_W : 1;

  logic [WR_DATA_W-1:0] mem [DEPTH];
  logic [WR_ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [SUB_W-1:0]     rd_sub;
  logic [WR_ADDR_W:0]   wide_cnt;

  logic [DATA_RATIO-1:0][RD_DATA_W-1:0] head;
  logic [RD_ADDR_W:0]   narrow_cnt;
  logic                 rd_last, wr_acc, rd_acc, slot_free;

  assign rd_last    = (rd_sub == SUB_W'(DATA_RATIO - 1));
  assign narrow_cnt = ((RD_ADDR_W+1)'(wide_cnt) << EXTEND_W) - (RD_ADDR_W+1)'(rd_sub);

  assign wr_full_o  = (wide_cnt == (WR_ADDR_W+1)'(DEPTH));
  assign rd_empty_o = (narrow_cnt == '0);
  assign wr_empty_o = rd_empty_o;
  assign rd_full_o  = (narrow_cnt == (RD_ADDR_W+1)'(2 ** RD_ADDR_W));
  assign wr_usedw_o = wide_cnt;
  assign rd_usedw_o = narrow_cnt;

  assign wr_acc    = wr_en_i && !wr_full_o;
  assign rd_acc    = rd_en_i && !rd_empty_o;
  // the wide slot is only released once its top slice is consumed
  assign slot_free = rd_acc && rd_last;

  assign head      = mem[rd_ptr];
  assign rd_data_o = head[rd_sub];

  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_sub   <= '0;
      wide_cnt <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        if (rd_last) begin
          rd_sub <= '0;
          rd_ptr <= rd_ptr + 1'b1;
        end else begin
          rd_sub <= rd_sub + 1'b1;
        end
      end
      case ({wr_acc, slot_free})
        2'b10:   wide_cnt <= wide_cnt + 1'b1;
        2'b01:   wide_cnt <= wide_cnt - 1'b1;
        default: wide_cnt <= wide_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_generic_sc_adapter_fifo_core.sv
// Directed and randomized checks of the 32->16 adapter FIFO against a
// halfword queue model.
module tb_generic_sc_adapter_fifo_core;

  logic        clk = 1'b0;
  logic        rst, wr_en, rd_en;
  logic [31:0] wr_data;
  logic [5:0]  wr_usedw;
  logic        wr_empty, wr_full;
  logic [15:0] rd_data;
  logic [6:0]  rd_usedw;
  logic        rd_empty, rd_full;

  int tests = 0;
  int fails = 0;
  logic [15:0] q[$];

  always #5 clk = ~clk;

  generic_sc_adapter_fifo_core #(.WR_ADDR_W(5), .WR_DATA_W(32), .RD_DATA_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .wr_en_i(wr_en), .wr_data_i(wr_data), .wr_usedw_o(wr_usedw),
    .wr_empty_o(wr_empty), .wr_full_o(wr_full),
    .rd_en_i(rd_en), .rd_data_o(rd_data), .rd_usedw_o(rd_usedw),
    .rd_empty_o(rd_empty), .rd_full_o(rd_full)
  );

  // one clock with the given request; model decides acceptance from pre-edge state
  task automatic cyc(input logic we, input logic [31:0] wd, input logic re);
    bit wa, ra;
    wa = we && (((q.size() + 1) / 2) < 32);
    ra = re && (q.size() != 0);
    wr_en = we; wr_data = wd; rd_en = re;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    if (ra) q.delete(0);
    if (wa) begin q.push_back(wd[15:0]); q.push_back(wd[31:16]); end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
  endtask

  function automatic logic [31:0] word(input int i);
    return {16'(16'h1000 + 2*i + 1), 16'(16'h1000 + 2*i)};
  endfunction

  task automatic test_reset();
    cyc(1'b1, 32'h12345678, 1'b0);
    do_reset();
    tests++; if (wr_usedw !== 6'd0) begin fails++; $display("FAIL reset_wr_usedw got %0d exp 0", wr_usedw); end
    tests++; if (rd_usedw !== 7'd0) begin fails++; $display("FAIL reset_rd_usedw got %0d exp 0", rd_usedw); end
    tests++; if ({wr_empty, rd_empty} !== 2'b11) begin fails++; $display("FAIL reset_empty got %b exp 11", {wr_empty, rd_empty}); end
    tests++; if ({wr_full, rd_full} !== 2'b00) begin fails++; $display("FAIL reset_full got %b exp 00", {wr_full, rd_full}); end
  endtask

  task automatic test_single();
    do_reset();
    cyc(1'b1, 32'hDDCCBBAA, 1'b0);
    tests++; if (rd_usedw !== 7'd2) begin fails++; $display("FAIL single_rd_usedw got %0d exp 2", rd_usedw); end
    tests++; if (wr_usedw !== 6'd1) begin fails++; $display("FAIL single_wr_usedw got %0d exp 1", wr_usedw); end
    tests++; if (rd_data !== 16'hBBAA) begin fails++; $display("FAIL single_lo got %h exp bbaa", rd_data); end
    cyc(1'b0, '0, 1'b1);
    tests++; if (rd_data !== 16'hDDCC) begin fails++; $display("FAIL single_hi got %h exp ddcc", rd_data); end
    tests++; if ({rd_usedw, wr_usedw} !== {7'd1, 6'd1}) begin fails++; $display("FAIL single_partial got %0d/%0d exp 1/1", rd_usedw, wr_usedw); end
    cyc(1'b0, '0, 1'b1);
    tests++; if ({rd_empty, wr_empty, rd_usedw} !== {2'b11, 7'd0}) begin fails++; $display("FAIL single_empty got %b%b/%0d exp 11/0", rd_empty, wr_empty, rd_usedw); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 32; i++) cyc(1'b1, word(i), 1'b0);
    tests++; if ({wr_full, rd_full} !== 2'b11) begin fails++; $display("FAIL fill_flags got %b exp 11", {wr_full, rd_full}); end
    tests++; if (rd_usedw !== 7'd64) begin fails++; $display("FAIL fill_rd_usedw got %0d exp 64", rd_usedw); end
    tests++; if (wr_usedw !== 6'd32) begin fails++; $display("FAIL fill_wr_usedw got %0d exp 32", wr_usedw); end
    cyc(1'b1, 32'hDEADBEEF, 1'b0);
    tests++; if (rd_usedw !== 7'd64) begin fails++; $display("FAIL fill_drop got %0d exp 64", rd_usedw); end
    for (int i = 0; i < 64; i++) begin
      tests++;
      if (rd_data !== 16'(16'h1000 + i)) begin fails++; $display("FAIL fill_order[%0d] got %h exp %h", i, rd_data, 16'(16'h1000 + i)); end
      cyc(1'b0, '0, 1'b1);
    end
    tests++; if (rd_empty !== 1'b1) begin fails++; $display("FAIL fill_drained got %b exp 1", rd_empty); end
  endtask

  task automatic test_partial_slot();
    int acc;
    do_reset();
    for (int i = 0; i < 32; i++) cyc(1'b1, word(i), 1'b0);
    for (int i = 0; i < 63; i++) cyc(1'b0, '0, 1'b1);
    tests++; if ({rd_usedw, wr_usedw, wr_full} !== {7'd1, 6'd1, 1'b0}) begin fails++; $display("FAIL partial_state got %0d/%0d/%b exp 1/1/0", rd_usedw, wr_usedw, wr_full); end
    tests++; if (rd_data !== 16'h103F) begin fails++; $display("FAIL partial_head got %h exp 103f", rd_data); end
    acc = 0;
    for (int i = 0; i < 32; i++) begin
      if (!wr_full) acc++;
      cyc(1'b1, word(100 + i), 1'b0);
    end
    tests++; if (acc !== 31) begin fails++; $display("FAIL partial_accepts got %0d exp 31", acc); end
    tests++; if ({wr_full, rd_usedw} !== {1'b1, 7'd63}) begin fails++; $display("FAIL partial_full got %b/%0d exp 1/63", wr_full, rd_usedw); end
    for (int i = 0; i < 63; i++) begin
      tests++;
      if (rd_data !== q[0]) begin fails++; $display("FAIL partial_drain[%0d] got %h exp %h", i, rd_data, q[0]); end
      cyc(1'b0, '0, 1'b1);
    end
    tests++; if (rd_empty !== 1'b1) begin fails++; $display("FAIL partial_empty got %b exp 1", rd_empty); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, word(i), 1'b0);
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (rd_data !== q[0]) begin fails++; $display("FAIL simul_data[%0d] got %h exp %h", i, rd_data, q[0]); end
      cyc(1'b1, word(20 + i), 1'b1);
      tests++;
      if (rd_usedw !== 7'(9 + i)) begin fails++; $display("FAIL simul_usedw[%0d] got %0d exp %0d", i, rd_usedw, 9 + i); end
    end
    while (q.size() != 0) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    tests++; if ({rd_usedw, rd_empty} !== {7'd0, 1'b1}) begin fails++; $display("FAIL empty_read got %0d/%b exp 0/1", rd_usedw, rd_empty); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, word(i), 1'b0);
    cyc(1'b0, '0, 1'b1);
    do_reset();
    tests++; if ({rd_usedw, wr_usedw, rd_empty} !== {7'd0, 6'd0, 1'b1}) begin fails++; $display("FAIL reset_mid got %0d/%0d/%b exp 0/0/1", rd_usedw, wr_usedw, rd_empty); end
    cyc(1'b1, 32'hCAFEF00D, 1'b0);
    tests++; if (rd_data !== 16'hF00D) begin fails++; $display("FAIL reset_mid_head got %h exp f00d", rd_data); end
  endtask

  task automatic test_random();
    logic we, re;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      we = ($urandom_range(0, 99) < ((i < 300) ? 60 : 25));
      re = ($urandom_range(0, 99) < 70);
      if (q.size() != 0) begin
        tests++;
        if (rd_data !== q[0]) begin fails++; $display("FAIL rand_data[%0d] got %h exp %h", i, rd_data, q[0]); end
      end
      cyc(we, $urandom, re);
      tests++;
      if (rd_usedw !== 7'(q.size()) || wr_usedw !== 6'((q.size() + 1) / 2)) begin
        fails++; $display("FAIL rand_usedw[%0d] got %0d/%0d exp %0d/%0d", i, rd_usedw, wr_usedw, q.size(), (q.size() + 1) / 2);
      end
    end
    while (q.size() != 0) begin
      tests++;
      if (rd_data !== q[0]) begin fails++; $display("FAIL rand_drain got %h exp %h", rd_data, q[0]); end
      cyc(1'b0, '0, 1'b1);
    end
    tests++; if (rd_empty !== 1'b1) begin fails++; $display("FAIL rand_empty got %b exp 1", rd_empty); end
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    test_reset();
    test_single();
    test_fill_drain();
    test_partial_slot();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
